// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg_scan_pkg;

    localparam int NIBBLE_W = 4;

    // Per-slot phase: anodes dark (BLANK) or one digit driven (SHOW).
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Slot counter: counts 0..REFRESH_DIV-1 and flags the last blanking cycle
// and the last cycle of the slot.
module seg_scan_tick
    import seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_blank_end,
    output logic o_slot_end
);

    localparam int CNT_W = cnt_width(REFRESH_DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Free-running slot counter, wraps at the end of each slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                   r_cnt <= '0;
        else if (r_cnt == SLOT_LAST) r_cnt <= '0;
        else                         r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_blank_end = (r_cnt == BLANK_LAST);
    assign o_slot_end  = (r_cnt == SLOT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional build macro: SEG_SCAN_LEADING_ZERO_BLANK_EN (dark leading zeros).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] i_digits_in,
    input  logic                           i_load,
    input  logic [NUM_DIGITS-1:0]          i_digit_en,
    output logic [NIBBLE_W-1:0]            o_dec_nibble,
    output logic [NUM_DIGITS-1:0]          o_anode_n,
    output logic                           o_frame_tick
);

    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                               w_blank_end;
    logic                               w_slot_end;
    state_e                             r_state, w_state_nxt;
    logic [IDX_W-1:0]                   r_idx, w_idx_nxt;
    logic [NUM_DIGITS*NIBBLE_W-1:0]     r_shadow;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] w_shadow_nib;
    logic [NIBBLE_W-1:0]                r_nibble, w_nibble_nxt;
    logic [NUM_DIGITS-1:0]              r_anode_n, w_anode_n_nxt;
    logic                               r_frame_tick, w_frame_tick_nxt;
    logic                               r_first, w_first_nxt;
    logic [NUM_DIGITS-1:0]              w_suppress;
    logic                               w_lit;

    seg_scan_tick #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end)
    );

    assign w_shadow_nib = r_shadow;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // Digit k>0 goes dark when it and every more significant nibble are zero.
    assign w_suppress[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_sup
        assign w_suppress[k] = ~|r_shadow[NUM_DIGITS*NIBBLE_W-1 : k*NIBBLE_W];
    end
`else
    assign w_suppress = '0;
`endif

    // Shadow register: captures a new display value on the load strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_shadow <= '0;
        else if (i_load) r_shadow <= i_digits_in;
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= BLANK;
            r_idx        <= '0;
            r_nibble     <= '0;
            r_anode_n    <= '1;
            r_frame_tick <= 1'b0;
            r_first      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_nibble     <= w_nibble_nxt;
            r_anode_n    <= w_anode_n_nxt;
            r_frame_tick <= w_frame_tick_nxt;
            r_first      <= w_first_nxt;
        end
    end

    // Next-state logic. The nibble only changes at slot boundaries (plus the
    // very first SHOW after reset) so the decoder input never moves mid-slot.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_nibble_nxt     = r_nibble;
        w_anode_n_nxt    = r_anode_n;
        w_frame_tick_nxt = 1'b0;
        w_first_nxt      = r_first;
        w_lit            = i_digit_en[r_idx] & ~w_suppress[r_idx];
        case (r_state)
            BLANK: begin
                w_anode_n_nxt = '1;
                if (w_blank_end) begin
                    w_state_nxt          = SHOW;
                    w_anode_n_nxt[r_idx] = ~w_lit;
                    if (r_first) begin
                        w_nibble_nxt = w_shadow_nib[r_idx];
                        w_first_nxt  = 1'b0;
                    end
                end
            end
            SHOW: begin
                if (w_slot_end) begin
                    w_state_nxt      = BLANK;
                    w_anode_n_nxt    = '1;
                    w_idx_nxt        = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                    w_nibble_nxt     = w_shadow_nib[w_idx_nxt];
                    w_frame_tick_nxt = (r_idx == LAST_IDX);
                end
            end
            default: begin
                w_state_nxt = BLANK;
            end
        endcase
    end

    assign o_dec_nibble = r_nibble;
    assign o_anode_n    = r_anode_n;
    assign o_frame_tick = r_frame_tick;

endmodule
